// File: rtl/bus_bridge_periph.sv
// bus_bridge_periph: CPU data-bus responder routing accesses to DRAM or to internal
// LED/switch/button/timer/7-segment registers with zero-latency combinational reads.
module bus_bridge_periph #(
  parameter int DRAM_AW  = 14,
  parameter int SCAN_DIV = 20000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        addr_from_cpu,
  input  logic               wen_from_cpu,
  input  logic [31:0]        wdata_from_cpu,
  output logic [31:0]        rdata_to_cpu,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dn_seg
);
  localparam int scan_w = $clog2(SCAN_DIV);
  localparam logic [15:0][7:0] seg_lut = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  logic              periph, we, hit, scan_end;
  logic [9:0]        woff;
  logic [31:0]       disp, cnt, div, presc, reg_val;
  logic [23:0]       sw_s1, sw_s2;
  logic [4:0]        btn_s1, btn_s2;
  logic [scan_w-1:0] scan;
  logic [2:0]        idx;
  assign periph     = addr_from_cpu[31:12] == 20'hFFFFF;
  assign woff       = addr_from_cpu[11:2];
  assign we         = wen_from_cpu & periph;
  assign dram_addr  = addr_from_cpu[DRAM_AW+1:2];
  assign dram_wen   = wen_from_cpu & ~periph;
  assign dram_wdata = wdata_from_cpu;
  assign hit        = presc == div;
  assign scan_end   = scan == scan_w'(SCAN_DIV - 1);
  always_comb
    reg_val = woff == 10'h000 ? disp :
              woff == 10'h008 ? cnt :
              woff == 10'h009 ? div :
              woff == 10'h018 ? {8'h0, led} :
              woff == 10'h01C ? {8'h0, sw_s2} :
              woff == 10'h01E ? {27'h0, btn_s2} : 32'h0;
  assign rdata_to_cpu = periph ? reg_val : dram_rdata;
  assign dig_en = ~(8'd1 << idx);
  assign dn_seg = seg_lut[disp[{idx, 2'b00} +: 4]];
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      disp   <= '0;
      led    <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= button;
      btn_s2 <= btn_s1;
      if (we && woff == 10'h000) disp <= wdata_from_cpu;
      if (we && woff == 10'h018) led <= wdata_from_cpu[23:0];
    end
  // A counter write overrides both the increment and the prescaler advance
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) begin
      cnt   <= '0;
      div   <= '0;
      presc <= '0;
    end else begin
      if (we && woff == 10'h009) div <= wdata_from_cpu;
      if (we && woff == 10'h008) begin
        cnt   <= wdata_from_cpu;
        presc <= '0;
      end else begin
        if (hit) cnt <= cnt + 32'd1;
        presc <= (hit || (we && woff == 10'h009)) ? '0 : presc + 32'd1;
      end
    end
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) begin
      scan <= '0;
      idx  <= '0;
    end else begin
      scan <= scan_end ? '0 : scan + scan_w'(1);
      if (scan_end) idx <= idx + 3'd1;
    end
endmodule
